mem_store_unit: RTL and testbench

Memory-side responder for the store path of the multicycle processor. It accepts one store request per transaction from the control FSM, using size codes word/byte/half (0/1/2). Word stores are written directly. Byte and half stores run a read-modify-write: read the aligned word, merge the new lane, write back. It sits between the control/datapath and the single-port synchronous memory and reports busy/done so the controller needs no fixed wait states.

---
 rtl/mem_store_pkg.sv | 32 +++
 rtl/store_lane_merge.sv | 22 ++
 rtl/mem_store_unit.sv | 128 ++++++++++++
 tb/tb_mem_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_pkg.sv
// Shared encodings for the store path: size codes, FSM states and lane helpers.
// Used by both the store unit and the controller so size codes stay consistent.
package mem_store_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_WRITE   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Size code 3 is reserved and behaves as a word store.
   function automatic logic is_subword(input logic [1:0] sz);
      return (sz == SZ_BYTE) || (sz == SZ_HALF);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
      if (sz == SZ_HALF) return lo[0];
      if (sz == SZ_BYTE) return 1'b0;
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops a byte or half of store data into a read word.
// Little-endian lanes; word and reserved sizes pass the store data through.
module store_lane_merge
   import mem_store_pkg::*;
(
   input  logic [WORD_W-1:0] rdata,
   input  logic [WORD_W-1:0] wdata,
   input  logic [1:0]        size,
   input  logic [1:0]        addr_lo,
   output logic [WORD_W-1:0] merged
);

   always_comb begin
      merged = rdata;
      case (size)
         SZ_BYTE: merged[{addr_lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
         SZ_HALF: merged[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_store_unit.sv
// Store-path responder: word stores write directly, byte/half stores read-modify-write.
// Optional macro STORE_ALIGN_CHECK_EN rejects misaligned stores with an err pulse.
module mem_store_unit
   import mem_store_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [ADDR_W-1:0]  addr_q;
   logic [1:0]         size_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [DATA_W-1:0]  merged;

`ifdef STORE_ALIGN_CHECK_EN
   logic err_q, err_nx;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         size_q  <= SZ_WORD;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == ST_IDLE && req) begin
            addr_q  <= addr;
            size_q  <= size;
            wdata_q <= wdata;
         end
         if (state == ST_CAPTURE)
            rdata_q <= mem_rdata;
`ifdef STORE_ALIGN_CHECK_EN
         err_q <= err_nx;
`endif
      end
   end

   // The counter runs READ_LAT cycles in READ so CAPTURE lines up with valid read data.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
`ifdef STORE_ALIGN_CHECK_EN
      err_nx   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (req) begin
`ifdef STORE_ALIGN_CHECK_EN
               if (is_misaligned(size, addr[1:0])) begin
                  state_nx = ST_DONE;
                  err_nx   = 1'b1;
               end else
`endif
               if (is_subword(size)) begin
                  state_nx = ST_READ;
                  cnt_nx   = CNT_W'(READ_LAT - 1);
               end else begin
                  state_nx = ST_WRITE;
               end
            end
         end
         ST_READ: begin
            if (cnt == '0)
               state_nx = ST_CAPTURE;
            else
               cnt_nx = cnt - CNT_W'(1);
         end
         ST_CAPTURE: state_nx = ST_WRITE;
         ST_WRITE:   state_nx = ST_DONE;
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   store_lane_merge u_merge (
      .rdata   (rdata_q),
      .wdata   (wdata_q),
      .size    (size_q),
      .addr_lo (addr_q[1:0]),
      .merged  (merged)
   );

   always_comb begin
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      mem_wr    = (state == ST_WRITE);
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == ST_READ || state == ST_CAPTURE || state == ST_WRITE)
         mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (state == ST_WRITE)
         mem_wdata = merged;
`ifdef STORE_ALIGN_CHECK_EN
      err = err_q;
`else
      err = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed store cases plus random traffic,
// compared every cycle against a transaction-level timing and memory model.
module tb_mem_store_unit;

   localparam int L = 3;

   logic        clk;
   logic        rst;
   logic        req;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy, done, err, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_store_unit #(.ADDR_W(32), .DATA_W(32), .READ_LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Environment memory: 16 words, read data returned L cycles after the address.
   logic [31:0] env_mem [16];
   logic [31:0] apipe [L];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_idx;
   logic [31:0] poke_val;

   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) apipe[i] <= apipe[i-1];
      apipe[0] <= mem_addr;
      if (mem_wr) env_mem[mem_addr[5:2]] <= mem_wdata;
      else if (poke_en) env_mem[poke_idx] <= poke_val;
   end
   assign mem_rdata = env_mem[apipe[L-1][5:2]];

   int wr_pulses = 0;
   int err_pulses = 0;
   always @(posedge clk) begin
      if (mem_wr) wr_pulses++;
      if (err) err_pulses++;
   end

   // Reference model: schedule of cycles per accepted transaction plus its own memory.
   logic [31:0] ref_mem [16];
   int m_cyc = 0;
   int m_acc = -1, m_wr = -1, m_done = -1, m_err = -1;
   logic [31:0] exp_addr, exp_wdata;

   function automatic logic [31:0] expect_word(input logic [31:0] old, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] wd);
      int sh;
      if (sz == 2'd1) begin
         sh = int'(a[1:0]) * 8;
         return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd2) begin
         sh = a[1] ? 16 : 0;
         return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   always @(posedge clk) begin
      if (m_cyc == m_wr) ref_mem[exp_addr[5:2]] = exp_wdata;
      if (rst) begin
         m_acc = -1; m_wr = -1; m_done = -1; m_err = -1;
      end else if (!(m_acc < m_cyc && m_cyc <= m_done) && req) begin
         m_acc = m_cyc;
         m_err = -1;
         exp_addr  = {addr[31:2], 2'b00};
         exp_wdata = expect_word(ref_mem[addr[5:2]], size, addr, wdata);
`ifdef STORE_ALIGN_CHECK_EN
         if ((size == 2'd2 && addr[0]) || ((size == 2'd0 || size == 2'd3) && addr[1:0] != 2'b00)) begin
            m_wr = -1;
            m_done = m_cyc + 1;
            m_err = m_done;
         end else
`endif
         begin
            m_wr = (size == 2'd1 || size == 2'd2) ? m_cyc + L + 2 : m_cyc + 1;
            m_done = m_wr + 1;
         end
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      check_output("busy", 32'(busy), 32'(m_acc < m_cyc && m_cyc <= m_done));
      check_output("done", 32'(done), 32'(m_cyc == m_done));
      check_output("mem_wr", 32'(mem_wr), 32'(m_cyc == m_wr));
      check_output("err", 32'(err), 32'(m_cyc == m_err));
      if (m_cyc == m_wr) begin
         check_output("mem_addr", mem_addr, exp_addr);
         check_output("mem_wdata", mem_wdata, exp_wdata);
      end
   end

   task automatic poke_word(input int idx, input logic [31:0] val);
      ref_mem[idx] = val;
      poke_idx = 4'(idx);
      poke_val = val;
      poke_en  = 1'b1;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req = 1'b1; size = sz; addr = a; wdata = wd;
      @(negedge clk);
      req = 1'b0;
      repeat (L + 4) @(negedge clk);
   endtask

   int wr_before;
   int err_before;

   initial begin
      rst = 1'b1; req = 1'b0; size = 2'd0; addr = '0; wdata = '0;
      for (int i = 0; i < 16; i++) poke_word(i, $urandom);
      poke_word(4, 32'h11223344);
      poke_word(8, 32'h11223344);
      @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_mem_wr", 32'(mem_wr), 32'd0);
      check_output("reset_mem_addr", mem_addr, 32'd0);
      check_output("reset_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;

      apply_stimulus(2'd0, 32'h10, 32'hDEADBEEF);
      check_output("word_env_mem", env_mem[4], 32'hDEADBEEF);
      check_output("word_ref_mem", ref_mem[4], 32'hDEADBEEF);

      apply_stimulus(2'd1, 32'h22, 32'h000000AB);
      check_output("byte_env_mem", env_mem[8], 32'h11AB3344);
      check_output("byte_ref_mem", ref_mem[8], 32'h11AB3344);

      poke_word(4, 32'h11223344);
      apply_stimulus(2'd2, 32'h12, 32'h0000CAFE);
      check_output("half_hi_mem", env_mem[4], 32'hCAFE3344);
      poke_word(4, 32'h11223344);
      apply_stimulus(2'd2, 32'h10, 32'h0000CAFE);
      check_output("half_lo_mem", env_mem[4], 32'h1122CAFE);

      // Second request pulsed while busy must be dropped.
      wr_before = wr_pulses;
      @(negedge clk);
      req = 1'b1; size = 2'd1; addr = 32'h05; wdata = 32'h77;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      req = 1'b1; size = 2'd0; addr = 32'h30; wdata = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      repeat (L + 4) @(negedge clk);
      check_output("single_wr_pulse", 32'(wr_pulses - wr_before), 32'd1);

      // Reset during CAPTURE abandons the byte store.
      poke_word(8, 32'h11223344);
      wr_before = wr_pulses;
      @(negedge clk);
      req = 1'b1; size = 2'd1; addr = 32'h22; wdata = 32'hAB;
      @(negedge clk);
      req = 1'b0;
      repeat (L) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("rst_cap_busy", 32'(busy), 32'd0);
      check_output("rst_cap_done", 32'(done), 32'd0);
      check_output("rst_cap_mem_wr", 32'(mem_wr), 32'd0);
      repeat (L + 3) @(negedge clk);
      check_output("rst_cap_no_write", 32'(wr_pulses - wr_before), 32'd0);
      check_output("rst_cap_mem", env_mem[8], 32'h11223344);
      apply_stimulus(2'd1, 32'h21, 32'h000000CD);
      check_output("after_rst_byte", env_mem[8], 32'h1122CD44);

      // Half store at an odd address.
      poke_word(4, 32'h11223344);
      err_before = err_pulses;
      apply_stimulus(2'd2, 32'h13, 32'h0000CAFE);
`ifdef STORE_ALIGN_CHECK_EN
      check_output("misalign_mem", env_mem[4], 32'h11223344);
      check_output("misalign_err", 32'(err_pulses - err_before), 32'd1);
`else
      check_output("misalign_mem", env_mem[4], 32'hCAFE3344);
      check_output("misalign_err", 32'(err_pulses - err_before), 32'd0);
`endif

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 63) == 0);
         req   = $urandom_range(0, 1) == 1;
         size  = 2'($urandom_range(0, 3));
         addr  = 32'($urandom_range(0, 63));
         wdata = $urandom;
      end
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      repeat (L + 6) @(negedge clk);
      for (int i = 0; i < 16; i++)
         check_output("final_mem", env_mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
